// File: rtl/sensor_responder.sv
// Sensor endpoint: listens for a one-byte UART poll on rx and, when it names this
// sensor, answers on tx with the latched sample byte followed by its CRC-8.
module sensor_responder #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter logic [2:0]  SENSOR_ID    = 3'd1,
  parameter int unsigned TURNAROUND   = 16
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       rx,
  output logic       tx,
  input  logic [7:0] sensor_data,
  output logic       data_latched,
  output logic       busy
);

  localparam int unsigned   CW        = $clog2(CLKS_PER_BIT + TURNAROUND + 1);
  localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] TURN_LAST = CW'(TURNAROUND - 1);
  localparam logic [7:0]    POLL_BYTE = {5'b00000, SENSOR_ID};

  typedef enum logic [1:0] {RX_IDLE = 2'd0, RX_START = 2'd1, RX_BITS = 2'd2, RX_STOP = 2'd3} rx_state_t;
  typedef enum logic [1:0] {WAIT_POLL = 2'd0, TURN = 2'd1, SEND_DATA = 2'd2, SEND_CRC = 2'd3} seq_state_t;
  typedef enum logic [1:0] {TX_IDLE = 2'd0, TX_START = 2'd1, TX_BITS = 2'd2, TX_STOP = 2'd3} tx_state_t;

  // CRC-8, poly 0x07, init 0, no reflection; with a zero init the byte is the initial remainder
  function automatic logic [7:0] crc8(input logic [7:0] d);
    logic [7:0] c;
    c = d;
    for (int i = 0; i < 8; i++) begin
      if (c[7]) c = {c[6:0], 1'b0} ^ 8'h07;
      else      c = {c[6:0], 1'b0};
    end
    return c;
  endfunction

  logic            r_rx_meta, r_rx_sync, r_rx_prev;
  rx_state_t       r_rx_state, w_rx_next;
  logic [CW-1:0]   r_rx_cnt;
  logic [2:0]      r_rx_bit;
  logic [7:0]      r_rx_shift, r_sample;
  logic            r_rx_valid, w_rx_tick, w_rx_good;

  seq_state_t      r_seq, w_seq_next;
  tx_state_t       r_tx_state, w_tx_next;
  logic [CW-1:0]   r_tx_cnt;
  logic [2:0]      r_tx_bit, w_tx_bit_next;
  logic [7:0]      r_data, r_crc, w_tx_byte;
  logic            r_tx, w_tx_d, r_busy, r_latched;
  logic            w_hit, w_tx_tick, w_turn_done, w_frame_done;

  // rx synchronizer plus one delayed copy for falling-edge detection
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
    end
  end

  // receiver state, bit timer and shift register
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= CNT_ZERO;
      r_rx_bit   <= 3'd0;
      r_rx_shift <= 8'h00;
      r_rx_valid <= 1'b0;
      r_sample   <= 8'h00;
    end else begin
      r_rx_state <= w_rx_next;
      r_rx_valid <= w_rx_good;
      if (w_rx_good) r_sample <= sensor_data;
      if (r_rx_state == RX_IDLE || w_rx_tick) r_rx_cnt <= CNT_ZERO;
      else                                    r_rx_cnt <= r_rx_cnt + CNT_ONE;
      if (r_rx_state == RX_BITS && w_rx_tick) begin
        r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
        r_rx_bit   <= r_rx_bit + 3'd1;
      end else if (r_rx_state != RX_BITS) begin
        r_rx_bit <= 3'd0;
      end
    end
  end

  // receiver next state; start bit is re-checked at mid-bit to reject glitches
  always_comb begin
    w_rx_next = r_rx_state;
    if (r_rx_state == RX_START) w_rx_tick = (r_rx_cnt == HALF_LAST);
    else                        w_rx_tick = (r_rx_cnt == BIT_LAST);
    case (r_rx_state)
      RX_IDLE:  if (r_rx_prev && !r_rx_sync) w_rx_next = RX_START; else w_rx_next = RX_IDLE;
      RX_START: if (!w_rx_tick) w_rx_next = RX_START;
                else if (r_rx_sync) w_rx_next = RX_IDLE;
                else w_rx_next = RX_BITS;
      RX_BITS:  if (w_rx_tick && r_rx_bit == 3'd7) w_rx_next = RX_STOP; else w_rx_next = RX_BITS;
      RX_STOP:  if (w_rx_tick) w_rx_next = RX_IDLE; else w_rx_next = RX_STOP;
      default:  w_rx_next = RX_IDLE;
    endcase
  end

  assign w_rx_good    = (r_rx_state == RX_STOP) && w_rx_tick && r_rx_sync;
  assign w_hit        = r_rx_valid && (r_rx_shift == POLL_BYTE) && (r_seq == WAIT_POLL);
  assign w_tx_tick    = (r_tx_cnt == BIT_LAST);
  assign w_turn_done  = (r_seq == TURN) && (r_tx_cnt == TURN_LAST);
  assign w_frame_done = (r_tx_state == TX_STOP) && w_tx_tick;
  assign w_tx_byte    = (r_seq == SEND_DATA) ? r_data : r_crc;

  // sequencer/transmitter state and registered outputs
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_seq      <= WAIT_POLL;
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= CNT_ZERO;
      r_tx_bit   <= 3'd0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
      r_latched  <= 1'b0;
      r_data     <= 8'h00;
      r_crc      <= 8'h00;
    end else begin
      r_seq      <= w_seq_next;
      r_tx_state <= w_tx_next;
      r_tx_bit   <= w_tx_bit_next;
      r_tx       <= w_tx_d;
      r_busy     <= (w_seq_next != WAIT_POLL);
      r_latched  <= w_hit;
      if (r_seq == WAIT_POLL || w_turn_done || (r_tx_state != TX_IDLE && w_tx_tick))
        r_tx_cnt <= CNT_ZERO;
      else
        r_tx_cnt <= r_tx_cnt + CNT_ONE;
      if (w_hit) begin
        r_data <= r_sample;
        r_crc  <= crc8(r_sample);
      end
    end
  end

  // sequencer and transmitter next state; CRC frame starts straight out of the data stop bit
  always_comb begin
    w_seq_next = r_seq;
    w_tx_next  = r_tx_state;
    case (r_seq)
      WAIT_POLL: if (w_hit) w_seq_next = TURN; else w_seq_next = WAIT_POLL;
      TURN:      if (w_turn_done) w_seq_next = SEND_DATA; else w_seq_next = TURN;
      SEND_DATA: if (w_frame_done) w_seq_next = SEND_CRC; else w_seq_next = SEND_DATA;
      SEND_CRC:  if (w_frame_done) w_seq_next = WAIT_POLL; else w_seq_next = SEND_CRC;
      default:   w_seq_next = WAIT_POLL;
    endcase
    case (r_tx_state)
      TX_IDLE:  if (w_turn_done) w_tx_next = TX_START; else w_tx_next = TX_IDLE;
      TX_START: if (w_tx_tick) w_tx_next = TX_BITS; else w_tx_next = TX_START;
      TX_BITS:  if (w_tx_tick && r_tx_bit == 3'd7) w_tx_next = TX_STOP; else w_tx_next = TX_BITS;
      TX_STOP:  if (!w_tx_tick) w_tx_next = TX_STOP;
                else if (r_seq == SEND_DATA) w_tx_next = TX_START;
                else w_tx_next = TX_IDLE;
      default:  w_tx_next = TX_IDLE;
    endcase
  end

  // next line level, derived from the state being entered
  always_comb begin
    w_tx_bit_next = r_tx_bit;
    w_tx_d        = 1'b1;
    if (r_tx_state == TX_BITS && w_tx_tick) w_tx_bit_next = r_tx_bit + 3'd1;
    else if (r_tx_state != TX_BITS)         w_tx_bit_next = 3'd0;
    else                                    w_tx_bit_next = r_tx_bit;
    case (w_tx_next)
      TX_START: w_tx_d = 1'b0;
      TX_BITS:  w_tx_d = w_tx_byte[w_tx_bit_next];
      TX_STOP:  w_tx_d = 1'b1;
      TX_IDLE:  w_tx_d = 1'b1;
      default:  w_tx_d = 1'b1;
    endcase
  end

  assign tx           = r_tx;
  assign busy         = r_busy;
  assign data_latched = r_latched;

endmodule

// File: tb/tb_sensor_responder.sv
// Bench for sensor_responder: table vectors, random polls against a reference model,
// and hand-written sequences for glitch, busy overlap and mid-response reset.
module tb_sensor_responder;
  localparam int         CPB  = 4;
  localparam int         TURN = 16;
  localparam logic [2:0] SID  = 3'd1;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] sensor_data = 8'h00;
  logic       tx, data_latched, busy;

  sensor_responder #(.CLKS_PER_BIT(CPB), .SENSOR_ID(SID), .TURNAROUND(TURN)) dut (
    .clock(clock), .resetn(resetn), .rx(rx), .tx(tx),
    .sensor_data(sensor_data), .data_latched(data_latched), .busy(busy)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // line monitor: decodes tx frames and records pulse/busy events
  logic [7:0] byte_q[$];
  int         start_q[$];
  int latch_cnt = 0, latch_cyc = 0, rise_cnt = 0, fall_cyc = 0, stop_err = 0, lb_err = 0;
  bit         mon_on = 1'b0;
  int         mon_cnt = 0;
  logic [7:0] mon_sh = 8'h00;
  logic       prev_busy = 1'b0;

  always @(negedge clock) begin
    int k;
    if (!resetn) begin
      mon_on    = 1'b0;
      prev_busy = 1'b0;
    end else begin
      if (data_latched) begin
        latch_cnt++;
        latch_cyc = cyc;
        if (!busy) lb_err++;
      end
      if (busy && !prev_busy) rise_cnt++;
      if (!busy && prev_busy) fall_cyc = cyc;
      prev_busy = busy;
      if (!mon_on) begin
        if (!tx) begin
          mon_on = 1'b1;
          mon_cnt = 0;
          start_q.push_back(cyc);
        end
      end else begin
        mon_cnt++;
        if (mon_cnt % CPB == CPB / 2) begin
          k = mon_cnt / CPB;
          if (k == 0 && tx) stop_err++;
          else if (k >= 1 && k <= 8) mon_sh[k-1] = tx;
          else if (k == 9) begin
            if (!tx) stop_err++;
            byte_q.push_back(mon_sh);
            mon_on = 1'b0;
          end
        end
      end
    end
  end

  int n_cmp = 0, n_fail = 0;

  task automatic check(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, got, got, exp, exp);
    end
  endtask

  // reference CRC by polynomial long division of data*x^8 by x^8+x^2+x+1
  function automatic logic [7:0] ref_crc(input logic [7:0] d);
    logic [15:0] rem;
    rem = {d, 8'h00};
    for (int i = 15; i >= 8; i--)
      if (rem[i]) rem = rem ^ (16'h0107 << (i - 8));
    return rem[7:0];
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    logic [9:0] f;
    f = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = f[i];
      tick(CPB);
    end
    rx = 1'b1;
  endtask

  int s_byte, s_start, s_latch, s_rise, s_stop, s_lb;

  task automatic snap();
    s_byte = byte_q.size(); s_start = start_q.size(); s_latch = latch_cnt;
    s_rise = rise_cnt; s_stop = stop_err; s_lb = lb_err;
  endtask

  task automatic verify(input string tag, input bit hit, input logic [7:0] d, input logic [7:0] c);
    int n;
    n = hit ? 1 : 0;
    check({tag, ".latch_pulses"}, latch_cnt - s_latch, n);
    check({tag, ".busy_rises"}, rise_cnt - s_rise, n);
    check({tag, ".frames"}, byte_q.size() - s_byte, 2 * n);
    check({tag, ".frame_bits"}, stop_err - s_stop, 0);
    check({tag, ".latch_busy"}, lb_err - s_lb, 0);
    check({tag, ".busy_end"}, int'(busy), 0);
    check({tag, ".tx_end"}, int'(tx), 1);
    if (hit && byte_q.size() >= s_byte + 2 && start_q.size() >= s_start + 2) begin
      check({tag, ".data_byte"}, int'(byte_q[s_byte]), int'(d));
      check({tag, ".crc_byte"}, int'(byte_q[s_byte + 1]), int'(c));
      check({tag, ".turnaround"}, start_q[s_start] - latch_cyc, TURN);
      check({tag, ".crc_gap"}, start_q[s_start + 1] - start_q[s_start], 10 * CPB);
      check({tag, ".release"}, fall_cyc - start_q[s_start], 20 * CPB);
    end
  endtask

  task automatic run_poll(input string tag, input logic [7:0] poll, input logic stop_bit,
                          input logic [7:0] sd, input bit hit, input logic [7:0] d, input logic [7:0] c);
    snap();
    sensor_data = sd;
    send_frame(poll, stop_bit);
    tick(150);
    verify(tag, hit, d, c);
  endtask

  typedef struct {
    logic [7:0] poll;
    logic       stop_bit;
    logic [7:0] sd;
    bit         hit;
    logic [7:0] d;
    logic [7:0] c;
  } vec_t;

  vec_t       vecs[6];
  logic [7:0] p, sd;
  logic       st;
  bit         hit;
  int         w;

  initial begin
    vecs[0] = '{8'h01, 1'b1, 8'hFF, 1'b1, 8'hFF, 8'hF3};
    vecs[1] = '{8'h01, 1'b1, 8'h01, 1'b1, 8'h01, 8'h07};
    vecs[2] = '{8'h02, 1'b1, 8'h55, 1'b0, 8'h00, 8'h00};
    vecs[3] = '{8'h00, 1'b1, 8'h55, 1'b0, 8'h00, 8'h00};
    vecs[4] = '{8'h81, 1'b1, 8'h55, 1'b0, 8'h00, 8'h00};
    vecs[5] = '{8'h01, 1'b0, 8'h55, 1'b0, 8'h00, 8'h00};

    for (int i = 0; i < 3; i++) begin
      rx = ~rx;
      @(negedge clock);
      check("reset.tx", int'(tx), 1);
      check("reset.busy", int'(busy), 0);
      check("reset.latched", int'(data_latched), 0);
    end
    #1;
    rx = 1'b1;
    resetn = 1'b1;
    tick(5);

    for (int i = 0; i < 6; i++)
      run_poll($sformatf("vec%0d", i), vecs[i].poll, vecs[i].stop_bit, vecs[i].sd,
               vecs[i].hit, vecs[i].d, vecs[i].c);

    snap();
    rx = 1'b0;
    tick(1);
    rx = 1'b1;
    tick(60);
    verify("glitch", 1'b0, 8'h00, 8'h00);

    // second poll lands inside the CRC frame and must be ignored
    snap();
    sensor_data = 8'hA5;
    send_frame(8'h01, 1'b1);
    tick(40);
    sensor_data = 8'h3C;
    send_frame(8'h01, 1'b1);
    sensor_data = 8'hA5;
    tick(150);
    verify("busy_poll", 1'b1, 8'hA5, ref_crc(8'hA5));
    run_poll("after_busy", 8'h01, 1'b1, 8'h3C, 1'b1, 8'h3C, ref_crc(8'h3C));

    snap();
    sensor_data = 8'h00;
    send_frame(8'h01, 1'b1);
    w = 0;
    while (w < 200 && start_q.size() == s_start) begin
      tick(1);
      w++;
    end
    check("mid_rst.start_seen", start_q.size() - s_start, 1);
    tick(2 * CPB + 1);
    check("mid_rst.tx_low", int'(tx), 0);
    resetn = 1'b0;
    @(posedge clock);
    @(negedge clock);
    check("mid_rst.tx", int'(tx), 1);
    check("mid_rst.busy", int'(busy), 0);
    #1;
    resetn = 1'b1;
    tick(10);
    run_poll("post_rst", 8'h01, 1'b1, 8'h5A, 1'b1, 8'h5A, ref_crc(8'h5A));

    for (int i = 0; i < 16; i++) begin
      p   = ($urandom_range(0, 2) == 0) ? 8'($urandom) : {5'b00000, SID};
      st  = ($urandom_range(0, 4) != 0);
      sd  = 8'($urandom);
      hit = st && (p == {5'b00000, SID});
      run_poll($sformatf("rand%0d", i), p, st, sd, hit, sd, ref_crc(sd));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sensor_responder.md
# sensor_responder

Sensor-side endpoint of the shared serial bus, directly upstream of the bus arbiter. It listens on the arbiter's TX line for a one-byte poll. When the poll carries its own sensor number, it latches the current sensor sample and answers with two 8N1 UART frames on the shared RX line: the data byte, then a CRC-8 of that byte. The arbiter's receiver and checksum check consume these two frames.

## Interface
- CLKS_PER_BIT, 434: clock cycles per UART bit (50 MHz / 115200 baud).
- SENSOR_ID, 3'd1: this node's sensor number, range 1..7; 0 is reserved by the arbiter for collision.
- TURNAROUND, 16: idle cycles between poll acceptance and the response start bit.

- clock  in  1  system clock; the block's only clock.
- resetn  in  1  synchronous, active-low reset, sampled on the rising edge of clock.
- rx  in  1  serial poll from the arbiter; asynchronous; idle high.
- tx  out  1  serial response to the arbiter; idle high.
- sensor_data  in  8  current sensor sample; sampled only on poll acceptance.
- data_latched  out  1  one-cycle pulse when sensor_data is captured.
- busy  out  1  high from poll acceptance until the end of the CRC stop bit.

## Operation
- Framing is 8N1, LSB first: 1 start bit (0), 8 data bits, 1 stop bit (1).
- rx passes through a 2-flop synchronizer before use; all rx timing below is measured at the synchronizer output.
- **Receiver states.** RX_IDLE → RX_START → RX_BITS → RX_STOP → RX_IDLE.
  - RX_IDLE: a 1→0 transition moves to RX_START.
  - RX_START: at CLKS_PER_BIT/2 cycles the line is re-checked. If it is high, the start was a glitch and the receiver returns to RX_IDLE.
  - RX_BITS: each data bit is sampled CLKS_PER_BIT cycles after the previous sample.
  - RX_STOP: the stop bit is sampled the same way. A stop bit of 0 is a framing error: the byte is discarded with no other effect.
- **Poll match.** A valid byte is a poll hit only if it equals {5'b0, SENSOR_ID} and busy=0. Every other byte is ignored, as is any byte arriving while busy=1. The receiver keeps running while busy.
- **Sequencer states.** WAIT_POLL → TURN → SEND_DATA → SEND_CRC → WAIT_POLL.
  - Poll hit: sensor_data is captured into an 8-bit data register and the CRC register is computed from it in the same cycle.
  - CRC: CRC-8, polynomial 0x07 (x^8+x^2+x+1), init 0x00, no reflection, no final XOR, computed over the single data byte.
- **Transmitter states.** TX_IDLE → TX_START → TX_BITS → TX_STOP. Each bit is held for exactly CLKS_PER_BIT cycles.
- The CRC frame's start bit immediately follows the data frame's stop bit, with no idle gap.
- Reset mid-operation: all state returns to idle and any partial frame is abandoned. tx goes high on the first clock edge with resetn=0.

## Timing
- Reset values: tx=1, busy=0, data_latched=0, all FSMs idle, all counters 0.
- Cycle A is the clock edge that samples the poll's stop bit as 1.
- **Acceptance.** On edge A+1, data_latched=1 for one cycle and busy rises. sensor_data is captured from its value at edge A.
- **Turnaround.** tx stays 1 for TURNAROUND cycles. The data start bit begins at A+1+TURNAROUND.
- **Response length.** 20×CLKS_PER_BIT cycles from that start bit to the end of the CRC stop bit.
- **Release.** busy falls on the cycle the CRC stop bit ends. A new poll is accepted only if its stop bit is sampled after that point.
- **Simultaneous events.** A poll hit and busy=1 in the same cycle: busy wins and the poll is ignored.

## Test plan
- **Reset.** Hold resetn=0 for 3 cycles with rx toggling. Required: tx=1, busy=0, data_latched=0 throughout.
- **Matching poll.** Use CLKS_PER_BIT=4, SENSOR_ID=1, sensor_data=0xFF; send poll 0x01. Required:
  - data_latched pulses once;
  - after 16 idle cycles, tx carries frame 0xFF then frame 0xF3 (80 cycles total);
  - busy then falls.
  - Repeating with sensor_data=0x01 yields response bytes 0x01 and 0x07.
- **Non-matching and reserved polls.** Send poll 0x02, then 0x00, then 0x81. Required: tx stays high, busy=0, no data_latched pulse.
- **Bad framing.** Send poll 0x01 with stop bit 0. Separately, send a 1-cycle low glitch on idle rx. Required: no response for either.
- **Poll while busy.** Send a second 0x01 poll during the CRC frame. Required: exactly one two-byte response; a third poll sent after busy falls gets a fresh response.
- **Reset mid-response.** Assert resetn=0 for 1 cycle during a data bit that is 0. Required: tx=1 on the next edge and busy=0. A following 0x01 poll gets a complete, correct response.
